// File: rtl/noc_switch_alloc.sv
// Five-port wormhole switch allocator: round-robin head arbitration per output,
// packet lock until tail, zero-cycle combinational grants from registered state.
module noc_switch_alloc (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req_valid_i,
  input  logic [2:0] req_port_addr1_i,
  input  logic [2:0] req_port_addr2_i,
  input  logic [2:0] req_port_addr3_i,
  input  logic [2:0] req_port_addr4_i,
  input  logic [2:0] req_port_addr5_i,
  input  logic [4:0] head_i,
  input  logic [4:0] tail_i,
  input  logic [4:0] out_ready_i,
  output logic [4:0] gnt_o,
  output logic [2:0] req_port_addr1_o,
  output logic [2:0] req_port_addr2_o,
  output logic [2:0] req_port_addr3_o,
  output logic [2:0] req_port_addr4_o,
  output logic [2:0] req_port_addr5_o,
  output logic [4:0] lock_o
);

  localparam int unsigned NP = 5;
  localparam int unsigned AW = 3;
  localparam logic [AW-1:0] NONE = 3'b111;

  logic [AW-1:0] addr [NP];
  logic [NP-1:0] locked_q, locked_n;
  logic [AW-1:0] owner_q [NP];
  logic [AW-1:0] owner_n [NP];
  logic [AW-1:0] ptr_q [NP];
  logic [AW-1:0] ptr_n [NP];
  logic [NP-1:0] grant_vld;
  logic [AW-1:0] grant_idx [NP];
  logic [AW:0]   cand;
  logic [AW-1:0] idx;

  assign addr[0] = req_port_addr1_i;
  assign addr[1] = req_port_addr2_i;
  assign addr[2] = req_port_addr3_i;
  assign addr[3] = req_port_addr4_i;
  assign addr[4] = req_port_addr5_i;

  // Per-output grant: locked outputs serve only their owner, idle ones round-robin over heads.
  always_comb begin
    grant_vld = '0;
    cand      = '0;
    idx       = '0;
    for (int o = 0; o < NP; o++) begin
      grant_idx[o] = NONE;
    end
    for (int o = 0; o < NP; o++) begin
      if (!rst && out_ready_i[o]) begin
        if (locked_q[o]) begin
          if (req_valid_i[owner_q[o]] && (addr[owner_q[o]] == AW'(o))) begin
            grant_vld[o] = 1'b1;
            grant_idx[o] = owner_q[o];
          end
        end else begin
          for (int k = 0; k < NP; k++) begin
            cand = {1'b0, ptr_q[o]} + (AW+1)'(k);
            if (cand >= (AW+1)'(NP)) cand = cand - (AW+1)'(NP);
            idx = cand[AW-1:0];
            if (!grant_vld[o] && req_valid_i[idx] && head_i[idx] &&
                (addr[idx] == AW'(o))) begin
              grant_vld[o] = 1'b1;
              grant_idx[o] = idx;
            end
          end
        end
      end
    end
  end

  // Lock, owner and pointer updates driven by this cycle's grants.
  always_comb begin
    locked_n = locked_q;
    for (int o = 0; o < NP; o++) begin
      owner_n[o] = owner_q[o];
      ptr_n[o]   = ptr_q[o];
    end
    for (int o = 0; o < NP; o++) begin
      if (grant_vld[o]) begin
        if (locked_q[o]) begin
          if (tail_i[owner_q[o]]) locked_n[o] = 1'b0;
        end else begin
          locked_n[o] = ~tail_i[grant_idx[o]];
          owner_n[o]  = grant_idx[o];
          ptr_n[o]    = (grant_idx[o] == AW'(NP-1)) ? '0 : grant_idx[o] + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q <= '0;
      for (int o = 0; o < NP; o++) begin
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      locked_q <= locked_n;
      for (int o = 0; o < NP; o++) begin
        owner_q[o] <= owner_n[o];
        ptr_q[o]   <= ptr_n[o];
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < NP; i++) begin
      for (int o = 0; o < NP; o++) begin
        if (grant_vld[o] && (grant_idx[o] == AW'(i))) gnt_o[i] = 1'b1;
      end
    end
  end

  assign req_port_addr1_o = grant_idx[0];
  assign req_port_addr2_o = grant_idx[1];
  assign req_port_addr3_o = grant_idx[2];
  assign req_port_addr4_o = grant_idx[3];
  assign req_port_addr5_o = grant_idx[4];
  assign lock_o           = rst ? '0 : locked_q;

endmodule

// File: tb/tb_noc_switch_alloc.sv
// Directed vector bench for noc_switch_alloc: cycle-by-cycle table plus a
// hand-written long-lock sequence.
module tb_noc_switch_alloc;

  typedef struct packed {
    logic        rst;
    logic [4:0]  valid;
    logic [14:0] addr;
    logic [4:0]  head;
    logic [4:0]  tail;
    logic [4:0]  ready;
    logic [4:0]  gnt;
    logic [14:0] oaddr;
    logic [4:0]  lock;
  } vec_t;

  localparam logic [14:0] IDL = 15'h7fff;

  logic        clk;
  logic        rst;
  logic [4:0]  req_valid, head, tail, out_ready;
  logic [14:0] addr_in;
  logic [4:0]  gnt, lock;
  logic [2:0]  oa1, oa2, oa3, oa4, oa5;
  logic [14:0] oaddr;
  int          checks;
  int          errors;
  vec_t        vecs[$];

  assign oaddr = {oa5, oa4, oa3, oa2, oa1};

  noc_switch_alloc dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid_i      (req_valid),
    .req_port_addr1_i (addr_in[2:0]),
    .req_port_addr2_i (addr_in[5:3]),
    .req_port_addr3_i (addr_in[8:6]),
    .req_port_addr4_i (addr_in[11:9]),
    .req_port_addr5_i (addr_in[14:12]),
    .head_i           (head),
    .tail_i           (tail),
    .out_ready_i      (out_ready),
    .gnt_o            (gnt),
    .req_port_addr1_o (oa1),
    .req_port_addr2_o (oa2),
    .req_port_addr3_o (oa3),
    .req_port_addr4_o (oa4),
    .req_port_addr5_o (oa5),
    .lock_o           (lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] a5(input logic [2:0] a0, input logic [2:0] a1,
                                     input logic [2:0] a2, input logic [2:0] a3,
                                     input logic [2:0] a4);
    return {a4, a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(input logic r, input logic [4:0] v, input logic [14:0] a,
                              input logic [4:0] h, input logic [4:0] t, input logic [4:0] rd,
                              input logic [4:0] g, input logic [14:0] oa, input logic [4:0] l);
    vec_t x;
    x.rst = r; x.valid = v; x.addr = a; x.head = h; x.tail = t; x.ready = rd;
    x.gnt = g; x.oaddr = oa; x.lock = l;
    return x;
  endfunction

  task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, compare on the falling edge, then advance past the rising edge.
  task automatic run(input vec_t v, input string tag);
    rst = v.rst; req_valid = v.valid; addr_in = v.addr;
    head = v.head; tail = v.tail; out_ready = v.ready;
    @(negedge clk);
    chk({tag, " gnt"},  15'(gnt),  15'(v.gnt));
    chk({tag, " addr"}, oaddr,     v.oaddr);
    chk({tag, " lock"}, 15'(lock), 15'(v.lock));
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t f;
    checks = 0;
    errors = 0;
    // Reset with every input active
    vecs.push_back(mk(1, 5'b11111, a5(0,0,0,0,0), 5'b11111, 5'b11111, 5'b11111, 5'b00000, IDL, 5'b00000));
    // Single-flit round robin on output 1 from inputs 0,2,4
    vecs.push_back(mk(0, 5'b10101, a5(1,1,1,1,1), 5'b10101, 5'b10101, 5'b11111, 5'b00001, a5(7,0,7,7,7), 5'b00000));
    vecs.push_back(mk(0, 5'b10101, a5(1,1,1,1,1), 5'b10101, 5'b10101, 5'b11111, 5'b00100, a5(7,2,7,7,7), 5'b00000));
    vecs.push_back(mk(0, 5'b10101, a5(1,1,1,1,1), 5'b10101, 5'b10101, 5'b11111, 5'b10000, a5(7,4,7,7,7), 5'b00000));
    vecs.push_back(mk(0, 5'b10101, a5(1,1,1,1,1), 5'b10101, 5'b10101, 5'b11111, 5'b00001, a5(7,0,7,7,7), 5'b00000));
    vecs.push_back(mk(1, 5'b00000, a5(0,0,0,0,0), 5'b00000, 5'b00000, 5'b11111, 5'b00000, IDL, 5'b00000));
    // 3-flit packet from input 3 on output 0; input 1 head waits until tail
    vecs.push_back(mk(0, 5'b01000, a5(0,0,0,0,0), 5'b01000, 5'b00000, 5'b11111, 5'b01000, a5(3,7,7,7,7), 5'b00000));
    vecs.push_back(mk(0, 5'b01010, a5(0,0,0,0,0), 5'b00010, 5'b00010, 5'b11111, 5'b01000, a5(3,7,7,7,7), 5'b00001));
    vecs.push_back(mk(0, 5'b01010, a5(0,0,0,0,0), 5'b00010, 5'b01010, 5'b11111, 5'b01000, a5(3,7,7,7,7), 5'b00001));
    vecs.push_back(mk(0, 5'b00010, a5(0,0,0,0,0), 5'b00010, 5'b00010, 5'b11111, 5'b00010, a5(1,7,7,7,7), 5'b00000));
    // Locked packet stalled by out_ready[0]=0 for two cycles, then reset mid-packet
    vecs.push_back(mk(0, 5'b01000, a5(0,0,0,0,0), 5'b01000, 5'b00000, 5'b11111, 5'b01000, a5(3,7,7,7,7), 5'b00000));
    vecs.push_back(mk(0, 5'b01000, a5(0,0,0,0,0), 5'b00000, 5'b00000, 5'b11110, 5'b00000, IDL, 5'b00001));
    vecs.push_back(mk(0, 5'b01000, a5(0,0,0,0,0), 5'b00000, 5'b00000, 5'b11110, 5'b00000, IDL, 5'b00001));
    vecs.push_back(mk(0, 5'b01000, a5(0,0,0,0,0), 5'b00000, 5'b00000, 5'b11111, 5'b01000, a5(3,7,7,7,7), 5'b00001));
    vecs.push_back(mk(1, 5'b01000, a5(0,0,0,0,0), 5'b00000, 5'b00000, 5'b11111, 5'b00000, IDL, 5'b00000));
    // After reset ptr[0]=0: input 2 beats input 4; input 3 body is not a head
    vecs.push_back(mk(0, 5'b11100, a5(0,0,0,0,0), 5'b10100, 5'b10100, 5'b11111, 5'b00100, a5(2,7,7,7,7), 5'b00000));
    // Invalid address and non-head to idle output
    vecs.push_back(mk(0, 5'b00011, a5(6,2,0,0,0), 5'b00001, 5'b00001, 5'b11111, 5'b00000, IDL, 5'b00000));
    vecs.push_back(mk(0, 5'b10010, a5(0,2,0,0,2), 5'b10010, 5'b10010, 5'b11111, 5'b00010, a5(7,7,1,7,7), 5'b00000));
    // All five outputs granted in one cycle
    vecs.push_back(mk(0, 5'b11111, a5(4,3,2,1,0), 5'b11111, 5'b11111, 5'b11111, 5'b11111, a5(4,3,2,1,0), 5'b00000));

    for (int i = 0; i < vecs.size(); i++) begin
      run(vecs[i], $sformatf("vec%0d", i));
    end

    // Owner of output 2 goes silent for a long time; lock holds and others stay blocked
    f = mk(0, 5'b00001, a5(2,2,2,2,2), 5'b00001, 5'b00000, 5'b11111, 5'b00001, a5(7,7,0,7,7), 5'b00000);
    run(f, "lock_start");
    for (int c = 0; c < 10; c++) begin
      f = mk(0, 5'b01010, a5(2,2,2,2,2), 5'b01010, 5'b01010, 5'b11111, 5'b00000, IDL, 5'b00100);
      run(f, $sformatf("lock_hold%0d", c));
    end
    f = mk(0, 5'b01011, a5(2,2,2,2,2), 5'b01010, 5'b01011, 5'b11111, 5'b00001, a5(7,7,0,7,7), 5'b00100);
    run(f, "lock_tail");
    f = mk(0, 5'b01010, a5(2,2,2,2,2), 5'b01010, 5'b01010, 5'b11111, 5'b00010, a5(7,7,1,7,7), 5'b00000);
    run(f, "after_unlock");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
